rand_word_gen: RTL and testbench

- Downstream consumer of the lfsr block's 4-bit `random_acc` stream.
- Assembles 4-bit nibbles into WORD_W-bit random words and buffers them in a small FIFO.
- Serves CPU random-number requests over a valid/ready handshake. Each request returns a uniformly distributed value in [0, limit) using mask-and-reject sampling.
- Throttles the LFSR via `lfsr_advance` when the buffer is full.

---
 rtl/rand_pkg.sv | 15 +
 rtl/rand_word_fifo.sv | 37 +++
 rtl/rand_word_gen.sv | 86 ++++++++
 tb/tb_rand_word_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// rand_pkg: shared constants, FSM states and the limit-to-mask helper for rand_word_gen.
package rand_pkg;
    localparam int WORD_W = 32;
    localparam int NIBBLES = WORD_W / 4;
    localparam int MAX_W = 64;
    typedef enum logic [1:0] {IDLE, DRAW, RESP} state_t;
    // Smear the bits of (limit-1) rightwards; limit=0 wraps to all-ones.
    function automatic logic [MAX_W-1:0] mask_for_limit(input logic [MAX_W-1:0] limit);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] mask;
        m = limit - MAX_W'(1);
        for (int i = 0; i < MAX_W; i++) mask[i] = |(m >> i);
        return mask;
    endfunction
endpackage

// File: rtl/rand_word_fifo.sv
// rand_word_fifo: DEPTH x WORD_W first-word-fall-through FIFO with async active-low reset.
module rand_word_fifo #(
    parameter int DEPTH = 2,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign o_full = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_data = r_mem[r_rd];
    assign w_pop = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    always_ff @(posedge clock)
        if (w_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
endmodule

// File: rtl/rand_word_gen.sv
// rand_word_gen: packs LFSR nibbles into words, buffers them, and serves
// bounded random requests by mask-and-reject sampling.
module rand_word_gen #(
    parameter int WORD_W = rand_pkg::WORD_W,
    parameter int DEPTH = 2,
    parameter int STRIDE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        random_acc,
    output logic              lfsr_advance,
    input  logic              req_valid,
    input  logic [WORD_W-1:0] req_limit,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_data,
    input  logic              resp_ready
);
    import rand_pkg::*;
    localparam int NIB = WORD_W / 4;
    localparam int CW = $clog2(NIB + 1);
    localparam int SW = STRIDE > 1 ? $clog2(STRIDE) : 1;
    state_t r_state, w_state_nx;
    logic r_run, r_valid;
    logic [WORD_W-1:0] r_word, r_limit, r_mask, r_data;
    logic [CW-1:0] r_nib, w_nib_base;
    logic [SW-1:0] r_stride;
    logic w_full, w_empty, w_pop, w_push, w_held, w_room, w_sample, w_last, w_accept;
    logic [WORD_W-1:0] w_shift, w_push_data, w_fifo_q, w_cand;
    // r_run keeps the handshake outputs low until the first edge after reset release.
    assign w_held = r_nib == CW'(NIB);
    assign w_pop = r_state == DRAW && !w_empty;
    assign w_room = !w_full || w_pop;
    assign lfsr_advance = r_run && !(w_held && !w_room);
    assign w_sample = lfsr_advance && r_stride == SW'(STRIDE - 1);
    assign w_last = w_sample && r_nib == CW'(NIB - 1);
    assign w_shift = {r_word[WORD_W-5:0], random_acc};
    assign w_push = (w_held || w_last) && w_room;
    assign w_push_data = w_held ? r_word : w_shift;
    assign w_nib_base = (w_held && w_push) ? '0 : r_nib;
    assign w_cand = w_fifo_q & r_mask;
    assign w_accept = w_pop && (r_limit == '0 || w_cand < r_limit);
    assign req_ready = r_run && r_state == IDLE;
    assign resp_valid = r_valid;
    assign resp_data = r_data;
    rand_word_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
        .clock(clock), .reset(reset), .i_push(w_push), .i_data(w_push_data), .i_pop(w_pop),
        .o_data(w_fifo_q), .o_full(w_full), .o_empty(w_empty)
    );
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_run <= 1'b0;
            r_word <= '0;
            r_nib <= '0;
            r_stride <= '0;
        end else begin
            r_run <= 1'b1;
            if (lfsr_advance) r_stride <= w_sample ? '0 : r_stride + SW'(1);
            if (w_sample) r_word <= w_shift;
            r_nib <= (w_last && w_push) ? '0 : w_nib_base + CW'(w_sample);
        end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data <= '0;
            r_limit <= '0;
            r_mask <= '0;
        end else begin
            r_state <= w_state_nx;
            if (req_valid && req_ready) begin
                r_limit <= req_limit;
                r_mask <= WORD_W'(mask_for_limit(MAX_W'(req_limit)));
            end
            if (w_accept) begin
                r_data <= w_cand;
                r_valid <= 1'b1;
            end else if (r_valid && resp_ready) r_valid <= 1'b0;
        end
    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && req_valid && req_ready) w_state_nx = DRAW;
        if (w_accept) w_state_nx = RESP;
        if (r_state == RESP && resp_ready) w_state_nx = IDLE;
    end
endmodule

// File: tb/tb_rand_word_gen.sv
// tb_rand_word_gen: scoreboard bench; expected responses come from a stream-level
// model of which LFSR nibbles land in which word and how draws are accepted.
module tb_rand_word_gen;
    localparam int W = 32;
    localparam int DEPTH = 2;
    localparam int STRIDE = 4;
    localparam int NIB = W / 4;
    localparam int SLEN = 8192;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [3:0] random_acc;
    logic lfsr_advance, req_ready, resp_valid;
    logic req_valid = 1'b0;
    logic resp_ready = 1'b1;
    logic rr_rand = 1'b0;
    logic rr_val = 1'b1;
    logic [W-1:0] req_limit = '0;
    logic [W-1:0] resp_data;
    logic [3:0] stream [SLEN];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_resp = '0;
    logic adv_at_pop = 1'b0;
    int step, checks, failures, model_j;

    rand_word_gen #(.WORD_W(W), .DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
        .clock(clock), .reset(reset), .random_acc(random_acc), .lfsr_advance(lfsr_advance),
        .req_valid(req_valid), .req_limit(req_limit), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
    );

    always #5 clock = ~clock;
    assign random_acc = stream[step % SLEN];

    // Stand-in LFSR: one stream position per advance cycle.
    always @(posedge clock or negedge reset)
        if (!reset) step <= 0;
        else if (lfsr_advance) step <= step + 1;

    always @(posedge clock) begin
        #1;
        resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock)
        if (reset && resp_valid && resp_ready) begin
            last_resp = resp_data;
            if (exp_q.size() == 0) check("unexpected_resp", resp_valid, 0);
            else check("resp_data", resp_data, exp_q.pop_front());
        end

    // Word j takes every STRIDE-th stream nibble, first one most significant.
    function automatic logic [W-1:0] model_word(input int j);
        logic [W-1:0] w = '0;
        for (int i = 0; i < NIB; i++)
            w = w * 16 + W'(stream[((j * NIB + i + 1) * STRIDE - 1) % SLEN]);
        return w;
    endfunction

    function automatic logic [W-1:0] ref_mask(input logic [W-1:0] lim);
        logic [63:0] m = 0;
        if (lim == 0) return '1;
        while (m < 64'(lim) - 1) m = m * 2 + 1;
        return m[W-1:0];
    endfunction

    task automatic model_req(input logic [W-1:0] lim, output logic [W-1:0] res);
        logic [W-1:0] c;
        do begin
            c = model_word(model_j) & ref_mask(lim);
            model_j++;
        end while (lim != 0 && c >= lim);
        res = c;
    endtask

    task automatic do_req(input logic [W-1:0] lim, input int exp_lat, output logic [W-1:0] res);
        int n = 0;
        model_req(lim, res);
        exp_q.push_back(res);
        do begin @(negedge clock); n++; end while (!req_ready && n < 2000);
        check("req_ready_wait", req_ready, 1);
        req_limit = lim;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        req_limit = $urandom;
        if (exp_lat > 0) begin
            n = 0;
            @(negedge clock);
            adv_at_pop = lfsr_advance;
            while (!resp_valid && n < 200) begin @(negedge clock); n++; end
            check("latency", n, exp_lat);
        end
    endtask

    task automatic wait_full();
        int n = 0;
        do begin @(negedge clock); n++; end while (lfsr_advance && n < 1000);
        check("fifo_fills", lfsr_advance, 0);
    endtask

    initial begin
        logic [W-1:0] r, lim;
        logic [W-1:0] w2 = 32'h1234567C;
        logic [W-1:0] w3 = 32'h9ABCDEF3;
        int n;
        for (int i = 0; i < SLEN; i++) stream[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4 * NIB * STRIDE / 4; i++) stream[i] = 4'(i % 16);
        for (int i = 0; i < NIB; i++) begin
            stream[(NIB + i + 1) * STRIDE - 1] = 4'(i + 1);
            stream[(2 * NIB + i + 1) * STRIDE - 1] = w2[W-1-4*i -: 4];
            stream[(3 * NIB + i + 1) * STRIDE - 1] = w3[W-1-4*i -: 4];
        end
        model_j = 0;
        req_valid = 1'b1;
        req_limit = 5;
        repeat (3) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_lfsr_advance", lfsr_advance, 0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_advance", lfsr_advance, 1);
        // Backpressure: two words in the FIFO plus one held stalls the LFSR.
        n = 0;
        while (step < 3 * NIB * STRIDE && n < 500) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        check("stall_advance", lfsr_advance, 0);
        check("stall_steps", step, 3 * NIB * STRIDE);
        repeat (10) @(negedge clock);
        check("stall_hold", step, 3 * NIB * STRIDE);
        do_req(0, 1, r);
        check("advance_in_pop", adv_at_pop, 1);
        @(negedge clock);
        check("stride_word", last_resp, 32'h37BF37BF);
        wait_full();
        do_req(0, 1, r);
        @(negedge clock);
        check("packed_word", last_resp, 32'h12345678);
        wait_full();
        do_req(10, 2, r);
        @(negedge clock);
        check("reject_result", last_resp, 3);
        // Response hold with the consumer stalled.
        wait_full();
        rr_val = 1'b0;
        @(negedge clock);
        do_req(0, 1, r);
        repeat (5) begin
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, r);
            check("hold_req_ready", req_ready, 0);
        end
        rr_val = 1'b1;
        // Randomized requests with random consumer backpressure.
        rr_rand = 1'b1;
        repeat (24) begin
            case ($urandom_range(0, 4))
                0: lim = 0;
                1: lim = W'($urandom_range(1, 20));
                2: lim = 32'd1 << $urandom_range(0, 31);
                3: lim = (32'd1 << $urandom_range(1, 30)) + 1;
                default: lim = $urandom;
            endcase
            do_req(lim, 0, r);
        end
        @(negedge clock);
        rr_rand = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clock); n++; end
        check("drain", exp_q.size(), 0);
        // Reset while waiting in DRAW on an empty FIFO drops the request.
        @(negedge clock);
        reset = 1'b0;
        model_j = 0;
        @(negedge clock);
        reset = 1'b1;
        do_req(5, 0, r);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        model_j = 0;
        #1;
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_advance", lfsr_advance, 0);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        repeat (40) begin @(negedge clock); if (resp_valid) n++; end
        check("no_resp_after_reset", n, 0);
        do_req(0, 0, r);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clock); n++; end
        check("first_word_after_reset", exp_q.size(), 0);
        check("restart_stride_word", last_resp, 32'h37BF37BF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
